rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_if.sv | 31 +++
 rtl/rst_seq_gap_cnt.sv | 40 ++++
 rtl/rst_seq.sv | 127 ++++++++++++
 tb/tb_rst_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and default constants for the staged
// reset-release sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RS_HOLD = 2'd0,
        RS_WAIT = 2'd1,
        RS_DONE = 2'd2
    } rst_seq_state_e;

    localparam int RST_SEQ_NUM_DOMAINS = 4;
    localparam int RST_SEQ_GAP_CYCLES  = 16;

    // Gap counter width; a single bit is kept even when GAP_CYCLES = 1.
    function automatic int rst_seq_cnt_w(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: system-reset input, stall input and the per-domain reset
// outputs of the reset-release sequencer, bundled for port connection.
interface rst_seq_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = RST_SEQ_NUM_DOMAINS
);
    logic                   sys_rst_ni;
    logic                   hold_i;
    logic [NUM_DOMAINS-1:0] periph_rst_no;
    logic                   busy_o;
    logic                   seq_done_o;

    // Reset manager / environment side.
    modport master (
        output sys_rst_ni,
        output hold_i,
        input  periph_rst_no,
        input  busy_o,
        input  seq_done_o
    );

    // Sequencer side.
    modport slave (
        input  sys_rst_ni,
        input  hold_i,
        output periph_rst_no,
        output busy_o,
        output seq_done_o
    );
endinterface

// File: rtl/rst_seq_gap_cnt.sv
// rst_seq_gap_cnt: loadable down-counter timing the gap between
// successive domain releases. Saturates at zero, never wraps.
module rst_seq_gap_cnt
    import rst_seq_pkg::*;
#(
    parameter int GAP_CYCLES = RST_SEQ_GAP_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);
    localparam int CNT_W = rst_seq_cnt_w(GAP_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(GAP_CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset-release sequencer. All peripheral domains are
// held in reset together and released one at a time in index order,
// GAP_CYCLES clock edges apart, once the system reset is deasserted.
// Optional feature macro: RST_SEQ_ASYNC_ASSERT_EN -- when defined, a low
// sys_rst_ni forces periph_rst_no low combinationally; release timing
// is unchanged. When undefined, all outputs are purely registered.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = RST_SEQ_NUM_DOMAINS,
    parameter int GAP_CYCLES  = RST_SEQ_GAP_CYCLES
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    rst_seq_if.slave bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    rst_seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] periph_q, periph_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;

    rst_seq_gap_cnt #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .zero_o (cnt_zero)
    );

    // Next-state and next-output logic; a low system reset overrides everything.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        periph_d = periph_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        if (!bus.sys_rst_ni) begin
            state_d  = RS_HOLD;
            idx_d    = '0;
            periph_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                RS_HOLD: begin
                    periph_d = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b0;
                    if (!bus.hold_i) begin
                        state_d  = RS_WAIT;
                        idx_d    = '0;
                        cnt_load = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                RS_WAIT: begin
                    busy_d = 1'b1;
                    if (!bus.hold_i) begin
                        if (!cnt_zero) begin
                            cnt_en = 1'b1;
                        end else begin
                            periph_d[idx_q] = 1'b1;
                            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                                state_d = RS_DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end else begin
                                idx_d    = idx_q + 1'b1;
                                cnt_load = 1'b1;
                            end
                        end
                    end
                end
                RS_DONE: begin
                    periph_d = '1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
                default: begin
                    state_d  = RS_HOLD;
                    idx_d    = '0;
                    periph_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b0;
                end
            endcase
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RS_HOLD;
            idx_q    <= '0;
            periph_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            periph_q <= periph_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef RST_SEQ_ASYNC_ASSERT_EN
    assign bus.periph_rst_no = periph_q & {NUM_DOMAINS{bus.sys_rst_ni}};
`else
    assign bus.periph_rst_no = periph_q;
`endif
    assign bus.busy_o     = busy_q;
    assign bus.seq_done_o = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq. Two instances share stimulus:
// dut_a with GAP_CYCLES=4 and dut_b with GAP_CYCLES=1, both 4 domains.
// The reference model counts un-held sequencing edges since start; the
// number of released domains is that count divided by the gap.
module tb_rst_seq;
    localparam int N = 4;

`ifdef RST_SEQ_ASYNC_ASSERT_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    logic clk_i  = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;
    logic sys_r  = 1'b0;
    logic hold_r = 1'b0;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];
    event sample_ev;

    // Reference model state per instance.
    int run  [2];
    int prog [2];
    int gap  [2];

    rst_seq_if #(.NUM_DOMAINS(N)) if_a ();
    rst_seq_if #(.NUM_DOMAINS(N)) if_b ();

    assign if_a.sys_rst_ni = sys_r;
    assign if_a.hold_i     = hold_r;
    assign if_b.sys_rst_ni = sys_r;
    assign if_b.hold_i     = hold_r;

    rst_seq #(.NUM_DOMAINS(N), .GAP_CYCLES(4)) dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_n),
        .bus    (if_a)
    );

    rst_seq #(.NUM_DOMAINS(N), .GAP_CYCLES(1)) dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_n),
        .bus    (if_b)
    );

    always #5 if (clk_en) clk_i = ~clk_i;

    always @(posedge clk_i) ->sample_ev;

    function automatic int rel(input int d);
        int r;
        r = prog[d] / gap[d];
        return (r > N) ? N : r;
    endfunction

    function automatic logic [5:0] outs(input int d, input logic m);
        logic [4:0] t;
        logic [3:0] p;
        logic       busy;
        logic       done;
        t    = (5'd1 << rel(d)) - 5'd1;
        p    = t[3:0] & {4{m}};
        busy = (run[d] != 0) && (rel(d) < N);
        done = (run[d] != 0) && (rel(d) == N);
        return {p, busy, done};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            run[d]  = 0;
            prog[d] = 0;
        end
    endtask

    task automatic model_edge(input logic s, input logic h);
        for (int d = 0; d < 2; d++) begin
            if (!s) begin
                run[d]  = 0;
                prog[d] = 0;
            end else if (run[d] == 0) begin
                if (!h) begin
                    run[d]  = 1;
                    prog[d] = 0;
                end
            end else if ((rel(d) < N) && !h) begin
                prog[d] = prog[d] + 1;
            end
        end
    endtask

    task automatic push_exp(input logic mid);
        exp_t e;
        logic m;
        m = 1'b1;
        if (mid && MASK_ON) m = sys_r;
        e.a = outs(0, m);
        e.b = outs(1, m);
        exp_q.push_back(e);
    endtask

    // One clock: drive at the falling edge, check the mid-cycle outputs,
    // then queue the outputs expected after the next rising edge.
    task automatic step(input logic s, input logic h);
        @(negedge clk_i);
        sys_r  = s;
        hold_r = h;
        push_exp(1'b1);
        ->sample_ev;
        model_edge(s, h);
        push_exp(1'b0);
    endtask

    task automatic run_steps(input int n, input logic s, input logic h);
        for (int i = 0; i < n; i++) step(s, h);
    endtask

    // Asynchronous reset pulse with the clock stopped.
    task automatic async_pulse();
        @(negedge clk_i);
        clk_en = 1'b0;
        #2;
        rst_n  = 1'b0;
        sys_r  = 1'b0;
        hold_r = 1'b0;
        model_reset();
        #1;
        push_exp(1'b0);
        ->sample_ev;
        #4;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
    endtask

    // Monitor: pop one expectation per sample point and compare both DUTs.
    initial begin
        exp_t e;
        logic [5:0] got_a;
        logic [5:0] got_b;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                got_a = {if_a.periph_rst_no, if_a.busy_o, if_a.seq_done_o};
                got_b = {if_b.periph_rst_no, if_b.busy_o, if_b.seq_done_o};
                total++;
                if (got_a !== e.a) begin
                    bad++;
                    $display("FAIL gap4 t=%0t got periph/busy/done=%b want=%b", $time, got_a, e.a);
                end
                total++;
                if (got_b !== e.b) begin
                    bad++;
                    $display("FAIL gap1 t=%0t got periph/busy/done=%b want=%b", $time, got_b, e.b);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        gap[0] = 4;
        gap[1] = 1;
        model_reset();

        // Reset state with no clock running.
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0);
        ->sample_ev;
        #2;
        rst_n = 1'b1;
        #2;
        clk_en = 1'b1;

        // Full sequence, then system reset falls while done.
        run_steps(20, 1'b1, 1'b0);
        run_steps(2, 1'b0, 1'b0);

        // System reset mid-sequence, then a full restart from domain 0.
        run_steps(10, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        run_steps(20, 1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Hold blocks the start, then stalls the sequence for three edges.
        run_steps(3, 1'b1, 1'b1);
        run_steps(2, 1'b1, 1'b0);
        run_steps(3, 1'b1, 1'b1);
        run_steps(20, 1'b1, 1'b0);
        run_steps(3, 1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Asynchronous reset mid-sequence, then an identical restart.
        run_steps(9, 1'b1, 1'b0);
        async_pulse();
        run_steps(20, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0));
        end

        @(posedge clk_i);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
